// File: rtl/spi_slave_tx_fifo_if.sv
//------------------------------------------------------------------------------
// Module      : spi_slave_tx_fifo_if
// Description : Valid/ready word stream feeding the SPI slave transmit FIFO,
//               plus the FIFO occupancy returned to the producer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_slave_tx_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]             in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic [$clog2(DEPTH+1)-1:0]   level;

   // Producer side: offers words, observes back-pressure and occupancy
   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  level
   );

   // FIFO side: accepts words, reports back-pressure and occupancy
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output level
   );
endinterface

`default_nettype wire

// File: rtl/spi_slave_tx_fifo.sv
//------------------------------------------------------------------------------
// Module      : spi_slave_tx_fifo
// Description : SPI slave transmitter running on the system clock. SCK/CSN
//               are synchronised and edge-detected; WIDTH-bit words are taken
//               from a DEPTH-entry FIFO and shifted out on MISO in any SPI
//               mode, MSB- or LSB-first. IDLE_WORD is sent on underrun.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_slave_tx_fifo #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter int               CPOL      = 0,
   parameter int               CPHA      = 0,
   parameter int               MSB_FIRST = 1,
   parameter logic [WIDTH-1:0] IDLE_WORD = '1
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              spi_sck,
   input  wire logic              spi_csn,
   output logic                   spi_sdo,
   output logic                   spi_sdo_oe,
   spi_slave_tx_fifo_if.slave     s_in,
   output logic                   word_done,
   output logic                   underrun,
   output logic [7:0]             underrun_cnt,
   output logic                   abort
);

   localparam int c_CNT_W = $clog2(WIDTH);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_LVL_W = $clog2(DEPTH + 1);

   localparam logic [c_CNT_W-1:0] c_last_bit   = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_penult_bit = c_CNT_W'(WIDTH - 2);
   localparam logic [c_LVL_W-1:0] c_full_level = c_LVL_W'(DEPTH);
   localparam logic               c_sck_idle   = (CPOL != 0);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Synchronisers and edge history
   logic r_sck_s1, r_sck_s2, r_sck_d;
   logic r_csn_s1, r_csn_s2, r_csn_d;

   // Control state
   state_t              r_state, w_state_nxt;
   logic [c_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [WIDTH-1:0]    r_shreg, w_shifted, w_load_word;
   logic                w_out_bit;

   // FIFO storage
   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wptr, r_rptr;
   logic [c_LVL_W-1:0]  r_level;

   // Status
   logic                r_word_done, r_underrun, r_abort;
   logic [7:0]          r_underrun_cnt;

   // Decoded events and actions
   logic w_sck_edge, w_lead, w_trail, w_csn_fall, w_csn_rise;
   logic w_load, w_shift, w_clear, w_word_done, w_abort;
   logic w_empty, w_push, w_pop, w_underrun;

   // Two-flop synchronisers plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_s1 <= c_sck_idle;
         r_sck_s2 <= c_sck_idle;
         r_sck_d  <= c_sck_idle;
         r_csn_s1 <= 1'b1;
         r_csn_s2 <= 1'b1;
         r_csn_d  <= 1'b1;
      end else begin
         r_sck_s1 <= spi_sck;
         r_sck_s2 <= r_sck_s1;
         r_sck_d  <= r_sck_s2;
         r_csn_s1 <= spi_csn;
         r_csn_s2 <= r_csn_s1;
         r_csn_d  <= r_csn_s2;
      end
   end

   // Leading edge leaves the idle level, trailing edge returns to it
   assign w_sck_edge = r_sck_s2 ^ r_sck_d;
   assign w_lead     = w_sck_edge && (r_sck_s2 != c_sck_idle);
   assign w_trail    = w_sck_edge && (r_sck_s2 == c_sck_idle);
   assign w_csn_fall = r_csn_d & ~r_csn_s2;
   assign w_csn_rise = ~r_csn_d & r_csn_s2;

   // FIFO head or IDLE_WORD; a same-cycle push never bypasses into the load
   assign w_empty     = (r_level == '0);
   assign w_push      = s_in.in_valid && s_in.in_ready;
   assign w_pop       = w_load && !w_empty;
   assign w_underrun  = w_load && w_empty;
   assign w_load_word = w_empty ? IDLE_WORD : r_mem[r_rptr];

   assign s_in.in_ready = (r_level != c_full_level);
   assign s_in.level    = r_level;

   // Shift direction and outgoing end bit depend on bit order
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
         assign w_out_bit = r_shreg[WIDTH-1];
      end else begin : g_lsb_first
         assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
         assign w_out_bit = r_shreg[0];
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath control; CSN rise always wins over SCK edges
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_load        = 1'b0;
      w_shift       = 1'b0;
      w_clear       = 1'b0;
      w_word_done   = 1'b0;
      w_abort       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_csn_fall) begin
               w_state_nxt   = ST_SHIFT;
               w_bit_cnt_nxt = '0;
               w_load        = (CPHA == 0);
               w_clear       = (CPHA != 0);
            end
         end
         ST_SHIFT: begin
            if (w_csn_rise) begin
               w_state_nxt   = ST_IDLE;
               w_bit_cnt_nxt = '0;
               w_clear       = 1'b1;
               w_abort       = (r_bit_cnt != '0);
            end else if (CPHA == 0) begin
               // bit_cnt counts bits already launched minus one
               if (w_trail) begin
                  if (r_bit_cnt == c_last_bit) begin
                     w_load        = 1'b1;
                     w_bit_cnt_nxt = '0;
                  end else begin
                     w_shift       = 1'b1;
                     w_word_done   = (r_bit_cnt == c_penult_bit);
                     w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                  end
               end
            end else begin
               // bit_cnt counts bits launched in the current word, 0 = boundary
               if (w_lead) begin
                  if (r_bit_cnt == '0) begin
                     w_load        = 1'b1;
                     w_bit_cnt_nxt = c_CNT_W'(1);
                  end else begin
                     w_shift       = 1'b1;
                     w_word_done   = (r_bit_cnt == c_last_bit);
                     w_bit_cnt_nxt = (r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Bit counter, shifter and event pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_word_done <= 1'b0;
         r_underrun  <= 1'b0;
         r_abort     <= 1'b0;
      end else begin
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_word_done <= w_word_done;
         r_underrun  <= w_underrun;
         r_abort     <= w_abort;
         if (w_load)       r_shreg <= w_load_word;
         else if (w_shift) r_shreg <= w_shifted;
         else if (w_clear) r_shreg <= '0;
      end
   end

   // FIFO pointers, occupancy and saturating underrun counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_level        <= '0;
         r_underrun_cnt <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_underrun && (r_underrun_cnt != 8'hFF))
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
      end
   end

   // FIFO storage; the head is read combinationally before this write lands
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= s_in.in_data;
   end

   assign spi_sdo_oe   = (r_state == ST_SHIFT);
   assign spi_sdo      = (r_state == ST_SHIFT) && w_out_bit;
   assign word_done    = r_word_done;
   assign underrun     = r_underrun;
   assign underrun_cnt = r_underrun_cnt;
   assign abort        = r_abort;

endmodule

`default_nettype wire
